// File: rtl/adc_frame_packer_if.sv
// Bus bundle between the frame packer, the ADC channel FIFOs and the byte-wide UART.
// The packer side takes the master modport; the FIFO/UART side takes the slave modport.
interface adc_frame_packer_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   ch_mask;
    logic [NUM_CH-1:0]   ch_rdempty;
    logic [8*NUM_CH-1:0] ch_data;
    logic [NUM_CH-1:0]   ch_rdreq;
    logic [NUM_CH-1:0]   ch_rearm;
    logic [7:0]          uart_data;
    logic                uart_send_en;
    logic                uart_tx_done;
    logic                busy;
    logic [15:0]         frame_cnt;

    modport master (
        input  ch_mask, ch_rdempty, ch_data, uart_tx_done,
        output ch_rdreq, ch_rearm, uart_data, uart_send_en, busy, frame_cnt
    );

    modport slave (
        output ch_mask, ch_rdempty, ch_data, uart_tx_done,
        input  ch_rdreq, ch_rearm, uart_data, uart_send_en, busy, frame_cnt
    );
endinterface

// File: rtl/adc_frame_packer.sv
// Round-robin multi-channel ADC FIFO drain that emits framed packets
// (sync, channel id, BLOCK_LEN samples, 8-bit checksum) over a send_en/tx_done UART.
module adc_frame_packer #(
    parameter int         NUM_CH    = 4,
    parameter int         BLOCK_LEN = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               Clk,
    input  logic               Reset_n,
    adc_frame_packer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CHID, S_RDREQ, S_RDWAIT, S_SEND, S_CSUM, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cur_ch;
    logic [2:0]  r_last_ch;
    logic [15:0] r_smp_cnt;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_csum;
    logic [7:0]  r_uart_data;
    logic        r_send_en;

    logic [NUM_CH-1:0] w_req;
    logic              w_hi_found;
    logic              w_lo_found;
    logic [2:0]        w_hi_ch;
    logic [2:0]        w_lo_ch;
    logic              w_found;
    logic [2:0]        w_cand;
    logic              w_cur_empty;
    logic [7:0]        w_cur_data;
    logic              w_tx_state;
    logic              w_byte_done;
    logic              w_last_smp;
    logic [NUM_CH-1:0] w_rdreq;
    logic [NUM_CH-1:0] w_rearm;
    logic              w_busy;

    // Lowest requesting channel above last_ch wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_req      = bus.ch_mask & ~bus.ch_rdempty;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_ch    = '0;
        w_lo_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                if (3'(i) > r_last_ch) begin
                    w_hi_found = 1'b1;
                    w_hi_ch    = 3'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_ch    = 3'(i);
                end
            end
        end
        w_found = w_hi_found | w_lo_found;
        w_cand  = w_hi_found ? w_hi_ch : w_lo_ch;
    end

    always_comb begin
        w_cur_empty = 1'b1;
        w_cur_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur_ch == 3'(i)) begin
                w_cur_empty = bus.ch_rdempty[i];
                w_cur_data  = bus.ch_data[8*i +: 8];
            end
        end
    end

    assign w_tx_state  = (r_state == S_HDR) || (r_state == S_CHID) ||
                         (r_state == S_SEND) || (r_state == S_CSUM);
    assign w_byte_done = r_send_en & bus.uart_tx_done;
    assign w_last_smp  = (r_smp_cnt == 16'(BLOCK_LEN - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found)      w_next = S_HDR;
            S_HDR:    if (w_byte_done)  w_next = S_CHID;
            S_CHID:   if (w_byte_done)  w_next = S_RDREQ;
            S_RDREQ:  if (!w_cur_empty) w_next = S_RDWAIT;
            S_RDWAIT:                   w_next = S_SEND;
            S_SEND:   if (w_byte_done)  w_next = w_last_smp ? S_CSUM : S_RDREQ;
            S_CSUM:   if (w_byte_done)  w_next = S_DONE;
            S_DONE:                     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdreq = '0;
        w_rearm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cur_ch == 3'(i)) begin
                w_rdreq[i] = (r_state == S_RDREQ) && !w_cur_empty;
                w_rearm[i] = (r_state == S_DONE);
            end
        end
        w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    end

    // Each byte state loads uart_data on entry, raises send_en one cycle later and
    // drops it on tx_done, which also leaves the state; that guarantees the low gap.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_cur_ch    <= '0;
            r_last_ch   <= 3'(NUM_CH - 1);
            r_smp_cnt   <= '0;
            r_frame_cnt <= '0;
            r_csum      <= '0;
            r_uart_data <= '0;
            r_send_en   <= 1'b0;
        end else begin
            if (!w_tx_state || w_byte_done) r_send_en <= 1'b0;
            else                            r_send_en <= 1'b1;

            case (r_state)
                S_IDLE: if (w_found) begin
                    r_cur_ch    <= w_cand;
                    r_smp_cnt   <= '0;
                    r_csum      <= '0;
                    r_uart_data <= SYNC_BYTE;
                end
                S_HDR: if (w_byte_done) begin
                    r_uart_data <= {5'b0, r_cur_ch};
                    r_csum      <= {5'b0, r_cur_ch};
                end
                S_RDWAIT: begin
                    r_uart_data <= w_cur_data;
                    r_csum      <= r_csum + w_cur_data;
                end
                S_SEND: if (w_byte_done) begin
                    if (w_last_smp) r_uart_data <= r_csum;
                    else            r_smp_cnt   <= r_smp_cnt + 16'd1;
                end
                S_DONE: begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_last_ch   <= r_cur_ch;
                end
                default: ;
            endcase
        end
    end

    assign bus.ch_rdreq     = w_rdreq;
    assign bus.ch_rearm     = w_rearm;
    assign bus.uart_data    = r_uart_data;
    assign bus.uart_send_en = r_send_en;
    assign bus.busy         = w_busy;
    assign bus.frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: FIFO and UART models driven from one thread,
// table-driven single-channel frames plus hand-written multi-cycle corner sequences.
module tb_adc_frame_packer;

    localparam int NUM_CH    = 4;
    localparam int BLOCK_LEN = 4;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    adc_frame_packer_if #(.NUM_CH(NUM_CH)) bus ();

    adc_frame_packer #(
        .NUM_CH   (NUM_CH),
        .BLOCK_LEN(BLOCK_LEN),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         ch;
        logic [7:0] smp [4];
        logic [7:0] csum;
        int         frames;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] fq [4][$];
    logic [7:0] tx_log [$];
    int         served [$];
    int         runs [$];
    int         rd_cnt [4];
    int         rearm_cnt [4];
    int         rearm_total;
    int         se_cnt;
    int         proto_viol = 0;

    int         uart_delay = 0;
    bit         active;
    int         wait_cnt;
    logic [7:0] act_data;
    logic       prev_done;
    logic       prev_se;
    logic [7:0] prev_data;
    int         run_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic refresh_empty();
        for (int i = 0; i < NUM_CH; i++) bus.ch_rdempty[i] = (fq[i].size() == 0);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        fq[ch].push_back(b);
        refresh_empty();
    endtask

    task automatic clear_logs();
        tx_log.delete();
        served.delete();
        runs.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            rd_cnt[i]    = 0;
            rearm_cnt[i] = 0;
        end
        rearm_total = 0;
        se_cnt      = 0;
    endtask

    task automatic reset_model();
        bus.uart_tx_done = 1'b0;
        active    = 1'b0;
        wait_cnt  = 0;
        act_data  = '0;
        prev_done = 1'b0;
        prev_se   = 1'b0;
        prev_data = '0;
        run_len   = 0;
    endtask

    // One clock: observe on the falling edge, update FIFO/UART inputs just after the rising edge.
    task automatic tick();
        logic [3:0] rd;
        logic       se;
        logic [7:0] dat;
        logic       nxt_done;
        @(negedge Clk);
        rd  = bus.ch_rdreq;
        se  = bus.uart_send_en;
        dat = bus.uart_data;
        if ($countones(rd) > 1) proto_viol++;
        if ((rd & bus.ch_rdempty) != 0) proto_viol++;
        if ((bus.ch_rearm != 0) && bus.busy) proto_viol++;
        if (prev_done && se) proto_viol++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd[i]) rd_cnt[i]++;
            if (bus.ch_rearm[i]) begin
                rearm_cnt[i]++;
                rearm_total++;
                served.push_back(i);
            end
        end
        if (se) begin
            if (!prev_se && dat != prev_data) proto_viol++;
            run_len++;
            se_cnt++;
        end else if (prev_se) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        nxt_done = 1'b0;
        if (bus.uart_tx_done) begin
            active = 1'b0;
        end else if (active) begin
            if (dat != act_data) proto_viol++;
            if (wait_cnt == 0) nxt_done = 1'b1;
            else               wait_cnt--;
        end else if (se) begin
            tx_log.push_back(dat);
            act_data = dat;
            active   = 1'b1;
            wait_cnt = uart_delay;
        end
        prev_done = bus.uart_tx_done;
        prev_se   = se;
        prev_data = dat;
        @(posedge Clk);
        #1;
        bus.uart_tx_done = nxt_done;
        for (int i = 0; i < NUM_CH; i++)
            if (rd[i] && fq[i].size() > 0) bus.ch_data[8*i +: 8] = fq[i].pop_front();
        refresh_empty();
    endtask

    task automatic wait_rearm(input string name, input int target, input int budget);
        int n = 0;
        while (rearm_total < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(rearm_total), 32'(target));
        tick();
    endtask

    task automatic wait_rd(input string name, input int ch, input int target, input int budget);
        int n = 0;
        while (rd_cnt[ch] < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(rd_cnt[ch]), 32'(target));
    endtask

    task automatic check_frame(input string name, input int base, input logic [55:0] exp);
        check({name, "_len"}, 32'(tx_log.size() >= base + 7), 32'd1);
        if (tx_log.size() >= base + 7)
            for (int j = 0; j < 7; j++)
                check(name, {24'd0, tx_log[base+j]}, {24'd0, exp[55-8*j -: 8]});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rdreq"},  {28'd0, bus.ch_rdreq}, 32'd0);
        check({name, "_rearm"},  {28'd0, bus.ch_rearm}, 32'd0);
        check({name, "_data"},   {24'd0, bus.uart_data}, 32'd0);
        check({name, "_senden"}, {31'd0, bus.uart_send_en}, 32'd0);
        check({name, "_busy"},   {31'd0, bus.busy}, 32'd0);
        check({name, "_fcnt"},   {16'd0, bus.frame_cnt}, 32'd0);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        reset_model();
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vec_t vecs [4];
        int   n;
        int   bad;
        int   se_snap;

        vecs[0].ch = 1; vecs[0].smp = '{8'h0A, 8'h14, 8'h1E, 8'h28}; vecs[0].csum = 8'h65; vecs[0].frames = 1;
        vecs[1].ch = 2; vecs[1].smp = '{8'hFF, 8'hFF, 8'h01, 8'h00}; vecs[1].csum = 8'h01; vecs[1].frames = 2;
        vecs[2].ch = 3; vecs[2].smp = '{8'h80, 8'h80, 8'h7D, 8'h00}; vecs[2].csum = 8'h80; vecs[2].frames = 3;
        vecs[3].ch = 0; vecs[3].smp = '{8'h00, 8'h00, 8'h00, 8'h00}; vecs[3].csum = 8'h00; vecs[3].frames = 4;

        bus.ch_mask    = '0;
        bus.ch_rdempty = '1;
        bus.ch_data    = '0;
        reset_model();
        clear_logs();

        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        tick();

        // Single-channel frames from the table
        for (int v = 0; v < 4; v++) begin
            clear_logs();
            bus.ch_mask = 4'(1 << vecs[v].ch);
            for (int s = 0; s < BLOCK_LEN; s++) push(vecs[v].ch, vecs[v].smp[s]);
            n = 0;
            while (!bus.uart_send_en && n < 8) begin
                tick();
                n++;
            end
            check("sync_latency", 32'(n), 32'd2);
            wait_rearm("vec_rearm_seen", 1, 200);
            check_frame("vec_bytes", 0, {8'hA5, 8'(vecs[v].ch), vecs[v].smp[0], vecs[v].smp[1],
                                         vecs[v].smp[2], vecs[v].smp[3], vecs[v].csum});
            check("vec_rdreq_cnt", 32'(rd_cnt[vecs[v].ch]), 32'd4);
            check("vec_rearm_cnt", 32'(rearm_cnt[vecs[v].ch]), 32'd1);
            check("vec_frame_cnt", {16'd0, bus.frame_cnt}, 32'(vecs[v].frames));
        end

        // Round robin across all channels from a fresh reset
        do_reset();
        clear_logs();
        for (int s = 0; s < 8; s++) push(0, 8'(s + 1));
        for (int c = 1; c < NUM_CH; c++)
            for (int s = 0; s < BLOCK_LEN; s++) push(c, 8'(16 * c + s));
        bus.ch_mask = 4'hF;
        wait_rearm("rr_rearm_seen", 5, 500);
        check("rr_frames", 32'(served.size()), 32'd5);
        if (served.size() == 5) begin
            check("rr_order0", 32'(served[0]), 32'd0);
            check("rr_order1", 32'(served[1]), 32'd1);
            check("rr_order2", 32'(served[2]), 32'd2);
            check("rr_order3", 32'(served[3]), 32'd3);
            check("rr_order4", 32'(served[4]), 32'd0);
        end
        check("rr_bytes", 32'(tx_log.size()), 32'd35);
        check("rr_rd_ch0", 32'(rd_cnt[0]), 32'd8);
        check("rr_frame_cnt", {16'd0, bus.frame_cnt}, 32'd5);

        // FIFO underflow mid-frame: stall in RDREQ, then resume
        clear_logs();
        bus.ch_mask = 4'b0010;
        push(1, 8'h05);
        push(1, 8'h06);
        repeat (40) tick();
        check("stall_bytes_before", 32'(tx_log.size()), 32'd4);
        se_snap = se_cnt;
        repeat (30) tick();
        check("stall_senden_cycles", 32'(se_cnt - se_snap), 32'd0);
        check("stall_rdreq_cnt", 32'(rd_cnt[1]), 32'd2);
        check("stall_busy", {31'd0, bus.busy}, 32'd1);
        push(1, 8'h07);
        push(1, 8'h08);
        wait_rearm("stall_rearm_seen", 1, 200);
        check_frame("stall_bytes", 0, {8'hA5, 8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1B});
        check("stall_rdreq_total", 32'(rd_cnt[1]), 32'd4);

        // Slow UART: tx_done arrives 100 cycles after send_en rises
        clear_logs();
        uart_delay = 98;
        bus.ch_mask = 4'b0100;
        for (int s = 1; s <= 4; s++) push(2, 8'(s));
        wait_rearm("slow_rearm_seen", 1, 2000);
        check_frame("slow_bytes", 0, {8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0C});
        check("slow_run_cnt", 32'(runs.size()), 32'd7);
        bad = 0;
        foreach (runs[k]) if (runs[k] != uart_delay + 3) bad++;
        check("slow_run_len", 32'(bad), 32'd0);
        uart_delay = 0;

        // Reset in the middle of the third sample
        clear_logs();
        bus.ch_mask = 4'b1000;
        for (int s = 0; s < 4; s++) push(3, 8'h09);
        wait_rd("rst_reach_third_read", 3, 3, 200);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset_model();
        tick();
        tick();
        check("midrst_no_reads", 32'(rd_cnt[3]), 32'd3);
        fq[3].delete();
        refresh_empty();
        Reset_n = 1'b1;
        clear_logs();
        bus.ch_mask = 4'b0001;
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        push(0, 8'h44);
        wait_rearm("post_rst_rearm_seen", 1, 200);
        check_frame("post_rst_bytes", 0, {8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
        check("post_rst_frame_cnt", {16'd0, bus.frame_cnt}, 32'd1);

        // Mask cleared mid-frame, with frame_cnt preloaded to wrap
        force dut.r_frame_cnt = 16'hFFFE;
        tick();
        release dut.r_frame_cnt;
        tick();
        check("preload_frame_cnt", {16'd0, bus.frame_cnt}, 32'h0000_FFFE);
        clear_logs();
        for (int s = 0; s < 4; s++) push(1, 8'h01);
        for (int s = 0; s < 4; s++) push(2, 8'h02);
        bus.ch_mask = 4'b0110;
        wait_rd("mask_first_read", 1, 1, 50);
        bus.ch_mask = 4'b0100;
        for (int s = 0; s < 4; s++) push(1, 8'h03);
        wait_rearm("mask_rearm_seen", 2, 400);
        repeat (60) tick();
        check_frame("mask_ch1_bytes", 0, {8'hA5, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h05});
        check_frame("mask_ch2_bytes", 7, {8'hA5, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h0A});
        check("mask_ch1_rearm", 32'(rearm_cnt[1]), 32'd1);
        check("mask_ch2_rearm", 32'(rearm_cnt[2]), 32'd1);
        check("mask_ch1_reads", 32'(rd_cnt[1]), 32'd4);
        check("mask_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("wrap_frame_cnt", {16'd0, bus.frame_cnt}, 32'd0);

        check("protocol_violations", 32'(proto_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
